bimux_xfer_ctrl: RTL and testbench

Sequencer and arbiter for the bidirectional 8:1 bit mux on the subleq machine's bit-serial bus. It owns the mux `dir`/`sel` controls and moves one byte per transaction. A read gathers the 8 parallel-side bits into a register via the serial node (`dir`=0). A write scatters a byte from the serial node onto the 8 parallel-side bits (`dir`=1). Read and write requesters share the single mux under round-robin arbitration with a req/ack handshake.

---
 rtl/bimux_xfer_ctrl.sv | 164 ++++++++++++++++
 tb/tb_bimux_xfer_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bimux_xfer_ctrl.sv
// bimux_xfer_ctrl: sequencer and round-robin arbiter for the 8:1
// bidirectional bit mux on the bit-serial bus; moves one byte per request.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rd_req/rd_ack      read handshake; rd_data is the gathered byte
//   wr_req/wr_ack      write handshake; wr_data is captured at grant
//   mux_dir, mux_sel   mux controls (dir 0 = parallel->serial)
//   ser_in             serial node value while mux_dir = 0
//   ser_out, ser_oe    serial node driver while mux_dir = 1
//   busy               high whenever a transaction is in progress
module bimux_xfer_ctrl #(
    parameter int SETTLE    = 0,
    parameter bit LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_req,
    output logic       rd_ack,
    output logic [7:0] rd_data,
    input  logic       wr_req,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       mux_dir,
    output logic [2:0] mux_sel,
    input  logic       ser_in,
    output logic       ser_out,
    output logic       ser_oe,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        XFER,
        DONE
    } state_t;

    localparam logic [2:0] FIRST    = LSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t     state;
    state_t     state_n;
    logic       op;        // 0 = read, 1 = write
    logic       op_n;
    logic       last_wr;   // type of the last completed grant
    logic       grant;
    logic [7:0] wbuf;
    logic [7:0] shift;
    logic [7:0] shift_n;
    logic [2:0] sel_q;
    logic [3:0] cnt;
    logic [2:0] nbit;
    logic       bit_end;
    logic       last_bit;

    // op only changes at grant, so it doubles as the held mux direction.
    assign mux_dir  = op;
    assign busy     = (state != IDLE);
    assign bit_end  = (cnt == SETTLE_C);
    assign last_bit = (nbit == 3'd7);

    always_comb begin
        shift_n        = shift;
        shift_n[sel_q] = ser_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        op_n    = op;
        grant   = 1'b0;
        rd_ack  = 1'b0;
        wr_ack  = 1'b0;
        ser_oe  = 1'b0;
        ser_out = 1'b0;
        mux_sel = 3'd0;
        unique case (state)
            IDLE: begin
                if (rd_req || wr_req) begin
                    grant   = 1'b1;
                    state_n = TURN;
                    // On a tie, hand the mux to the side that did not go last.
                    if (rd_req && wr_req) begin
                        op_n = ~last_wr;
                    end else begin
                        op_n = wr_req;
                    end
                end
            end
            TURN: begin
                mux_sel = sel_q;
                state_n = XFER;
            end
            XFER: begin
                mux_sel = sel_q;
                ser_oe  = op;
                ser_out = op & wbuf[sel_q];
                if (bit_end && last_bit) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                mux_sel = sel_q;
                rd_ack  = ~op;
                wr_ack  = op;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op      <= 1'b0;
            last_wr <= 1'b1;
            wbuf    <= 8'h00;
            shift   <= 8'h00;
            rd_data <= 8'h00;
            sel_q   <= 3'd0;
            cnt     <= 4'd0;
            nbit    <= 3'd0;
        end else begin
            op <= op_n;
            if (grant) begin
                if (op_n) begin
                    wbuf <= wr_data;
                end
                sel_q <= FIRST;
                cnt   <= 4'd0;
                nbit  <= 3'd0;
            end
            if (state == XFER) begin
                if (bit_end) begin
                    cnt <= 4'd0;
                    if (!op) begin
                        shift <= shift_n;
                    end
                    if (last_bit) begin
                        // Load on the way into DONE so rd_data is valid with rd_ack.
                        if (!op) begin
                            rd_data <= shift_n;
                        end
                    end else begin
                        nbit  <= nbit + 3'd1;
                        sel_q <= LSB_FIRST ? sel_q + 3'd1 : sel_q - 3'd1;
                    end
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
            if (state == DONE) begin
                last_wr <= op;
            end
        end
    end

endmodule

// File: tb/tb_bimux_xfer_ctrl.sv
// tb_bimux_xfer_ctrl: directed bench for bimux_xfer_ctrl with two
// instances (SETTLE=0/LSB_FIRST=1 and SETTLE=2/LSB_FIRST=0).
module tb_bimux_xfer_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       rd_req0 = 1'b0;
    logic       wr_req0 = 1'b0;
    logic [7:0] wr_data0 = 8'h00;
    logic [7:0] par0 = 8'h00;
    logic       ser_in0;
    logic       rd_ack0, wr_ack0, dir0, ser_out0, oe0, busy0;
    logic [7:0] rd_data0;
    logic [2:0] sel0;

    logic       rd_req1 = 1'b0;
    logic       wr_req1 = 1'b0;
    logic [7:0] wr_data1 = 8'h00;
    logic [7:0] par1 = 8'h00;
    logic       ser_in1;
    logic       rd_ack1, wr_ack1, dir1, ser_out1, oe1, busy1;
    logic [7:0] rd_data1;
    logic [2:0] sel1;

    assign ser_in0 = par0[sel0];
    assign ser_in1 = par1[sel1];

    bimux_xfer_ctrl u_dut0 (
        .clk(clk), .rst(rst),
        .rd_req(rd_req0), .rd_ack(rd_ack0), .rd_data(rd_data0),
        .wr_req(wr_req0), .wr_data(wr_data0), .wr_ack(wr_ack0),
        .mux_dir(dir0), .mux_sel(sel0),
        .ser_in(ser_in0), .ser_out(ser_out0), .ser_oe(oe0),
        .busy(busy0)
    );

    bimux_xfer_ctrl #(.SETTLE(2), .LSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .rst(rst),
        .rd_req(rd_req1), .rd_ack(rd_ack1), .rd_data(rd_data1),
        .wr_req(wr_req1), .wr_data(wr_data1), .wr_ack(wr_ack1),
        .mux_dir(dir1), .mux_sel(sel1),
        .ser_in(ser_in1), .ser_out(ser_out1), .ser_oe(oe1),
        .busy(busy1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus-safety monitor: the driver is only enabled in reverse direction,
    // and never switches on in the same cycle the direction flips.
    logic mon_en = 1'b0;
    logic dir0_p, oe0_p, dir1_p, oe1_p;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("oe0_dir", 32'(oe0 === 1'b1 && dir0 !== 1'b1), 32'd0);
            chk("oe0_turn", 32'(oe0 === 1'b1 && oe0_p === 1'b0 &&
                                dir0 !== dir0_p), 32'd0);
            chk("oe1_dir", 32'(oe1 === 1'b1 && dir1 !== 1'b1), 32'd0);
            chk("oe1_turn", 32'(oe1 === 1'b1 && oe1_p === 1'b0 &&
                                dir1 !== dir1_p), 32'd0);
        end
        dir0_p = dir0;
        oe0_p  = oe0;
        dir1_p = dir1;
        oe1_p  = oe1;
    end

    typedef struct {
        logic       rd_req;
        logic       chk_sel;
        logic [2:0] sel;
        logic       busy;
        logic       ack;
        logic [7:0] data;
    } rvec_t;

    rvec_t rtab[12];

    initial begin
        logic [7:0] wexp;
        logic [7:0] seq;
        int         ev_cyc[$];
        logic       ev_wr[$];
        int         b;

        rtab[0]  = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00};
        rtab[1]  = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00};
        for (int i = 2; i < 10; i++)
            rtab[i] = '{1'b1, 1'b1, 3'(i - 2), 1'b1, 1'b0, 8'h00};
        rtab[10] = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hA5};
        rtab[11] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'hA5};

        // Reset values
        rst = 1'b1;
        step();
        step();
        chk("rst_dir", 32'(dir0), 32'd0);
        chk("rst_sel", 32'(sel0), 32'd0);
        chk("rst_ser_out", 32'(ser_out0), 32'd0);
        chk("rst_oe", 32'(oe0), 32'd0);
        chk("rst_rd_ack", 32'(rd_ack0), 32'd0);
        chk("rst_wr_ack", 32'(wr_ack0), 32'd0);
        chk("rst_rd_data", 32'(rd_data0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Read 0xA5, SETTLE=0, LSB first, table-driven
        par0 = 8'hA5;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("rd_busy_c%0d", i), 32'(busy0), 32'(rtab[i].busy));
            chk($sformatf("rd_ack_c%0d", i), 32'(rd_ack0), 32'(rtab[i].ack));
            chk($sformatf("rd_data_c%0d", i), 32'(rd_data0),
                32'(rtab[i].data));
            chk($sformatf("rd_oe_c%0d", i), 32'(oe0), 32'd0);
            chk($sformatf("rd_dir_c%0d", i), 32'(dir0), 32'd0);
            chk($sformatf("rd_wack_c%0d", i), 32'(wr_ack0), 32'd0);
            if (rtab[i].chk_sel)
                chk($sformatf("rd_sel_c%0d", i), 32'(sel0), 32'(rtab[i].sel));
            rd_req0 = rtab[i].rd_req;
            step();
        end

        // Write 0x3C, SETTLE=2, MSB first
        wexp     = 8'h3C;
        wr_data1 = wexp;
        wr_req1  = 1'b1;
        seq      = 8'h00;
        for (int c = 0; c < 28; c++) begin
            chk($sformatf("wr_busy_c%0d", c), 32'(busy1),
                32'(c >= 1 && c <= 26));
            chk($sformatf("wr_ack_c%0d", c), 32'(wr_ack1), 32'(c == 26));
            chk($sformatf("wr_dir_c%0d", c), 32'(dir1), 32'(c >= 1));
            if (c >= 2 && c <= 25) begin
                b = (c - 2) / 3;
                chk($sformatf("wr_sel_c%0d", c), 32'(sel1), 32'(7 - b));
                chk($sformatf("wr_oe_c%0d", c), 32'(oe1), 32'd1);
                chk($sformatf("wr_sout_c%0d", c), 32'(ser_out1),
                    32'(wexp[7 - b]));
                if ((c - 2) % 3 == 0)
                    seq = {seq[6:0], ser_out1};
            end else begin
                chk($sformatf("wr_oe_c%0d", c), 32'(oe1), 32'd0);
                if (c == 1)
                    chk("wr_sel_turn", 32'(sel1), 32'd7);
                if (c == 0 || c == 27)
                    chk($sformatf("wr_sel_c%0d", c), 32'(sel1), 32'd0);
            end
            if (c == 1)
                wr_data1 = 8'hFF;
            if (c >= 26)
                wr_req1 = 1'b0;
            step();
        end
        chk("wr_ser_seq", 32'(seq), 32'h3C);

        // Simultaneous requests after reset alternate R, W, R
        rst = 1'b1;
        step();
        rst      = 1'b0;
        par0     = 8'h5A;
        wr_data0 = 8'h00;
        rd_req0  = 1'b1;
        wr_req0  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            chk($sformatf("tie_conc_c%0d", c), 32'(rd_ack0 & wr_ack0), 32'd0);
            if (rd_ack0 === 1'b1) begin
                ev_cyc.push_back(c);
                ev_wr.push_back(1'b0);
            end
            if (wr_ack0 === 1'b1) begin
                ev_cyc.push_back(c);
                ev_wr.push_back(1'b1);
            end
            if (c == 10)
                chk("tie_rd_data", 32'(rd_data0), 32'h5A);
            if (c == 33) begin
                rd_req0 = 1'b0;
                wr_req0 = 1'b0;
            end
            step();
        end
        chk("tie_nacks", 32'(ev_cyc.size()), 32'd3);
        if (ev_cyc.size() == 3) begin
            chk("tie_ev0_cyc", 32'(ev_cyc[0]), 32'd10);
            chk("tie_ev0_wr", 32'(ev_wr[0]), 32'd0);
            chk("tie_ev1_cyc", 32'(ev_cyc[1]), 32'd21);
            chk("tie_ev1_wr", 32'(ev_wr[1]), 32'd1);
            chk("tie_ev2_cyc", 32'(ev_cyc[2]), 32'd32);
            chk("tie_ev2_wr", 32'(ev_wr[2]), 32'd0);
        end

        // Write with request dropped at cycle 4, then a read
        wexp     = 8'h5A;
        wr_data0 = wexp;
        wr_req0  = 1'b1;
        par0     = 8'h11;
        for (int c = 0; c < 23; c++) begin
            chk($sformatf("wd_busy_c%0d", c), 32'(busy0),
                32'((c >= 1 && c <= 10) || (c >= 12 && c <= 21)));
            chk($sformatf("wd_wack_c%0d", c), 32'(wr_ack0), 32'(c == 10));
            chk($sformatf("wd_rack_c%0d", c), 32'(rd_ack0), 32'(c == 21));
            if (c >= 2 && c <= 9) begin
                chk($sformatf("wd_oe_c%0d", c), 32'(oe0), 32'd1);
                chk($sformatf("wd_sout_c%0d", c), 32'(ser_out0),
                    32'(wexp[c - 2]));
            end else begin
                chk($sformatf("wd_oe_c%0d", c), 32'(oe0), 32'd0);
            end
            if (c == 11) begin
                chk("wd_dir_hold", 32'(dir0), 32'd1);
                chk("wd_sel_idle", 32'(sel0), 32'd0);
            end
            if (c == 12)
                chk("wd_dir_turn", 32'(dir0), 32'd0);
            if (c == 21)
                chk("wd_rd_data", 32'(rd_data0), 32'h11);
            if (c == 1)
                wr_data0 = 8'hFF;
            if (c == 4)
                wr_req0 = 1'b0;
            if (c == 11)
                rd_req0 = 1'b1;
            if (c == 21)
                rd_req0 = 1'b0;
            step();
        end

        // Reset at cycle 5 of a read discards it
        par0    = 8'hFF;
        rd_req0 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c >= 1)
                chk($sformatf("rr_hold_c%0d", c), 32'(rd_data0), 32'h11);
            if (c == 5)
                rst = 1'b1;
            step();
        end
        chk("rr_dir", 32'(dir0), 32'd0);
        chk("rr_sel", 32'(sel0), 32'd0);
        chk("rr_ser_out", 32'(ser_out0), 32'd0);
        chk("rr_oe", 32'(oe0), 32'd0);
        chk("rr_rd_ack", 32'(rd_ack0), 32'd0);
        chk("rr_wr_ack", 32'(wr_ack0), 32'd0);
        chk("rr_rd_data", 32'(rd_data0), 32'd0);
        chk("rr_busy", 32'(busy0), 32'd0);
        rst     = 1'b0;
        rd_req0 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            chk($sformatf("rr_noack_c%0d", c), 32'(rd_ack0), 32'd0);
            chk($sformatf("rr_idle_c%0d", c), 32'(busy0), 32'd0);
        end

        // Request and reset in the same cycle: no grant
        rd_req0 = 1'b1;
        rst     = 1'b1;
        step();
        chk("rq_rst_busy", 32'(busy0), 32'd0);
        rst     = 1'b0;
        rd_req0 = 1'b0;
        step();
        chk("rq_rst_busy2", 32'(busy0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
